led_frame_scheduler: RTL and testbench

LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_bit_timer.sv | 29 ++
 rtl/led_frame_scheduler.sv | 125 ++++++++++++
 tb/tb_led_frame_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the LED frame scheduler
package led_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Serial index 0..7 maps to word[7..0], 8..15 maps to word[15..8].
  function automatic logic serial_bit(input logic [FRAME_W-1:0] word,
                                      input logic [3:0] idx);
    logic [3:0] pos;
    pos = {idx[3], ~idx[2:0]};
    return word[pos];
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// rtl/led_bit_timer.sv - CLK_DIV divider producing single-cycle half-period ticks
module led_bit_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [7:0] LP_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == LP_LAST);
  assign o_tick = w_last && !i_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - arbitrates two frame sources and shifts frames to a 16-bit LED chain
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned REFRESH_PERIOD = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [FRAME_W-1:0]  i_data0,
  input  logic [FRAME_W-1:0]  i_data1,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic                o_busy,
  output logic                o_sclk,
  output logic                o_data,
  output logic                o_latch
);

  localparam logic [23:0] LP_REFRESH_LAST = 24'(REFRESH_PERIOD - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FRAME_W-1:0]   r_frame;
  logic [3:0]           r_bit;
  logic                 r_phase;
  logic                 r_last;
  logic [23:0]          r_idle_cnt;

  logic                 w_tick;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_capture;
  logic                 w_refresh;
  logic [FRAME_W-1:0]   w_win_data;

  led_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (r_state == ST_IDLE),
    .o_tick (w_tick)
  );

  // r_last holds the index of the last granted requester; a tie goes to the other one.
  always_comb begin
    w_gnt = '0;
    if (r_state == ST_IDLE && !i_rst) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = '0;
      endcase
    end
  end

  assign w_capture  = |w_gnt;
  assign w_win_data = w_gnt[1] ? i_data1 : i_data0;
  assign w_refresh  = (r_state == ST_IDLE) && !w_capture && (r_idle_cnt == LP_REFRESH_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_capture || w_refresh) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick && r_phase && r_bit == 4'd15) begin
          w_state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (w_tick && r_phase) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_frame    <= '0;
      r_bit      <= '0;
      r_phase    <= 1'b0;
      r_last     <= 1'b1;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_capture) begin
        r_frame <= w_win_data;
        r_last  <= w_gnt[1];
      end

      if (r_state != ST_IDLE || w_capture || w_refresh) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 24'd1;
      end

      // Phase toggles low/high each tick; in LATCH the same two phases time the pulse.
      if (r_state == ST_IDLE) begin
        r_phase <= 1'b0;
        r_bit   <= '0;
      end else if (w_tick) begin
        r_phase <= ~r_phase;
        if (r_phase && r_state == ST_SHIFT) begin
          r_bit <= r_bit + 4'd1;
        end
      end
    end
  end

  assign o_gnt   = w_gnt;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_sclk  = (r_state == ST_SHIFT) && r_phase;
  assign o_data  = (r_state == ST_SHIFT) ? serial_bit(r_frame, r_bit) : 1'b0;
  assign o_latch = (r_state != ST_LATCH);

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb/tb_led_frame_scheduler.sv - directed self-checking bench for led_frame_scheduler
module tb_led_frame_scheduler;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req;
  logic [15:0] i_data0;
  logic [15:0] i_data1;
  logic [1:0]  o_gnt;
  logic        o_busy;
  logic        o_sclk;
  logic        o_data;
  logic        o_latch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_frame_scheduler #(
    .CLK_DIV        (2),
    .REFRESH_PERIOD (200)
  ) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_data0 (i_data0),
    .i_data1 (i_data1),
    .o_gnt   (o_gnt),
    .o_busy  (o_busy),
    .o_sclk  (o_sclk),
    .o_data  (o_data),
    .o_latch (o_latch)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until the block returns to IDLE, collecting the serial stream (first bit in MSB).
  task automatic watch(input int max_cyc, output logic [15:0] stream, output int nbits,
                       output int nlatch, output int nbusy, output int ngnt, output int nunstable);
    logic prev_sclk;
    logic prev_data;
    prev_sclk = 1'b0;
    prev_data = 1'b0;
    stream = '0;
    nbits = 0; nlatch = 0; nbusy = 0; ngnt = 0; nunstable = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (!o_busy && nbusy > 0) break;
      if (o_busy) nbusy++;
      if (!o_latch) nlatch++;
      if (o_gnt != 2'b00) ngnt++;
      if (o_sclk && o_data !== prev_data) nunstable++;
      if (o_sclk && !prev_sclk) begin
        stream = {stream[14:0], o_data};
        nbits++;
      end
      prev_sclk = o_sclk;
      prev_data = o_data;
    end
  endtask

  task automatic count_idle(output int nidle, output int ngnt);
    nidle = 1;
    ngnt = (o_gnt != 2'b00) ? 1 : 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (o_busy) break;
      nidle++;
      if (o_gnt != 2'b00) ngnt++;
    end
  endtask

  logic [15:0] s;
  int nb, nl, nbz, ng, nu, ni, ngi;

  initial begin
    i_rst = 1'b1; i_req = 2'b00; i_data0 = '0; i_data1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_sclk", o_sclk, 0);
    chk("rst_data", o_data, 0);
    chk("rst_latch", o_latch, 1);
    chk("rst_gnt", o_gnt, 0);

    // Basic frame 12A5 from requester 0
    i_rst = 1'b0;
    @(negedge clk);
    i_req = 2'b01; i_data0 = 16'h12A5;
    #1 chk("f1_gnt", o_gnt, 2'b01);
    @(posedge clk); #1 i_req = 2'b00;
    chk("f1_gnt_off", o_gnt, 0);
    chk("f1_busy", o_busy, 1);
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("f1_stream", s, 16'hA512);
    chk("f1_bits", nb, 16);
    chk("f1_latch", nl, 4);
    chk("f1_busy_cyc", nbz, 68);
    chk("f1_gnt_cnt", ng, 0);
    chk("f1_stable", nu, 0);

    // Round robin from reset with both requesting
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    i_req = 2'b11; i_data0 = 16'h1111; i_data1 = 16'h2222;
    #1 chk("rr_gnt1", o_gnt, 2'b01);
    @(posedge clk); #1;
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("rr_stream1", s, 16'h1111);
    chk("rr_gnt_in_frame1", ng, 0);
    chk("rr_gnt2", o_gnt, 2'b10);
    @(posedge clk); #1;
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("rr_stream2", s, 16'h2222);
    chk("rr_gnt3", o_gnt, 2'b01);
    @(posedge clk); #1 i_req = 2'b00;
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("rr_stream3", s, 16'h1111);

    // Refresh of FFFF after 200 idle cycles, twice
    @(negedge clk);
    i_req = 2'b10; i_data1 = 16'hFFFF;
    #1 chk("rf_gnt", o_gnt, 2'b10);
    @(posedge clk); #1 i_req = 2'b00;
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("rf_stream0", s, 16'hFFFF);
    count_idle(ni, ngi);
    chk("rf_idle1", ni, 200);
    chk("rf_idle1_gnt", ngi, 0);
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("rf_stream1", s, 16'hFFFF);
    chk("rf_busy1", nbz, 67);
    chk("rf_gnt1", ng, 0);
    chk("rf_latch1", nl, 4);
    count_idle(ni, ngi);
    chk("rf_idle2", ni, 200);
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("rf_stream2", s, 16'hFFFF);

    // Request on the refresh-expiry cycle wins
    repeat (198) @(negedge clk);
    chk("rx_pre_busy", o_busy, 0);
    @(negedge clk);
    chk("rx_exp_busy", o_busy, 0);
    i_req = 2'b10; i_data1 = 16'h3C5A;
    #1 chk("rx_gnt", o_gnt, 2'b10);
    @(posedge clk); #1 i_req = 2'b00;
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("rx_stream", s, 16'h5A3C);
    chk("rx_busy_cyc", nbz, 68);

    // Reset at bit 9 aborts without a latch pulse
    @(negedge clk);
    i_req = 2'b01; i_data0 = 16'hFFFF;
    #1 chk("ra_gnt", o_gnt, 2'b01);
    @(posedge clk); #1 i_req = 2'b00;
    nl = 0;
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      if (!o_latch) nl++;
    end
    chk("ra_data_b9", o_data, 1);
    i_rst = 1'b1;
    @(negedge clk);
    chk("ra_sclk", o_sclk, 0);
    chk("ra_data", o_data, 0);
    chk("ra_latch", o_latch, 1);
    chk("ra_busy", o_busy, 0);
    i_rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!o_latch) nl++;
      if (o_busy) nl++;
    end
    chk("ra_no_latch", nl, 0);

    // Requests toggled during SHIFT are ignored until IDLE
    i_req = 2'b01; i_data0 = 16'h0F0F;
    #1 chk("tg_gnt1", o_gnt, 2'b01);
    @(posedge clk); #1 i_req = 2'b00;
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      i_req = c[0] ? 2'b00 : 2'b01;
      #1 if (o_gnt != 2'b00) ng++;
    end
    chk("tg_no_gnt", ng, 0);
    i_req = 2'b01; i_data0 = 16'hABCD;
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("tg_no_gnt_rest", ng, 0);
    chk("tg_gnt2", o_gnt, 2'b01);
    @(posedge clk); #1 i_req = 2'b00;
    watch(200, s, nb, nl, nbz, ng, nu);
    chk("tg_stream", s, 16'hCDAB);
    chk("tg_gnt_cnt", ng, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
